counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 49 ++++
 rtl/counter.sv | 71 +++++++
 tb/tb_counter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared helpers for the wrapping counter: parameter legality, next-value and
// load-clamp arithmetic, and the per-cycle operation decode.
package counter_pkg;

    // Wide enough that count+step can never alias for any legal nbits/step.
    localparam int unsigned calc_w = 64;
    typedef logic [calc_w-1:0] calc_t;

    typedef enum logic [1:0] {
        op_hold  = 2'd0,
        op_clear = 2'd1,
        op_load  = 2'd2,
        op_step  = 2'd3
    } op_t;

    function automatic bit params_ok(input int nbits, input int min,
                                     input int max, input int step);
        return (nbits >= 1) && (nbits <= 31) && (min >= 0) && (min <= max) &&
               (step >= 1) && (longint'(max) < (longint'(1) << nbits));
    endfunction

    // Returns the value after one enabled step and flags a wrap; any overshoot
    // past max is dropped rather than carried into the wrapped value.
    function automatic calc_t next_value(input calc_t count, input calc_t step,
                                         input calc_t min, input calc_t max,
                                         output logic wrap);
        calc_t sum;
        sum  = count + step;
        wrap = (sum > max);
        return wrap ? min : sum;
    endfunction

    function automatic calc_t clamp(input calc_t value, input calc_t min,
                                    input calc_t max);
        if (value < min) return min;
        if (value > max) return max;
        return value;
    endfunction

    // Priority clr > load > en; reset is handled by the register itself.
    function automatic op_t decode_op(input logic clr, input logic load,
                                      input logic en);
        if (clr)       return op_clear;
        else if (load) return op_load;
        else if (en)   return op_step;
        else           return op_hold;
    endfunction

endpackage

// File: rtl/counter.sv
// Parameterised wrapping counter [min,max] with combinational overflow that
// marks the cycle before a wrap. Define COUNTER_LOAD_EN to add a clamped load.
module counter
    import counter_pkg::*;
#(
    parameter int nbits = 8,
    parameter int min   = 0,
    parameter int max   = 2**nbits - 1,
    parameter int step  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
`ifdef COUNTER_LOAD_EN
    input  logic             load,
    input  logic [nbits-1:0] load_value,
`endif
    output logic [nbits-1:0] count,
    output logic             overflow
);

    if (!params_ok(nbits, min, max, step)) begin : g_illegal_params
        $error("counter: illegal parameters nbits=%0d min=%0d max=%0d step=%0d",
               nbits, min, max, step);
    end

    localparam calc_t            min_c  = calc_t'(min);
    localparam calc_t            max_c  = calc_t'(max);
    localparam calc_t            step_c = calc_t'(step);
    localparam logic [nbits-1:0] min_q  = nbits'(min);

    op_t              op;
    logic             wrap;
    logic             load_req;
    logic [nbits-1:0] step_value;
    logic [nbits-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wrap       = 1'b0;
        step_value = nbits'(next_value(calc_t'(count), step_c, min_c, max_c, wrap));
`ifdef COUNTER_LOAD_EN
        load_req   = load;
`else
        load_req   = 1'b0;
`endif
        op         = decode_op(clr, load_req, en);
        count_d    = count;
        unique case (op)
            op_clear: count_d = min_q;
`ifdef COUNTER_LOAD_EN
            op_load:  count_d = nbits'(clamp(calc_t'(load_value), min_c, max_c));
`endif
            op_step:  count_d = step_value;
            default:  count_d = count;
        endcase
    end

    // High only in a stepping cycle that will wrap; clear and load suppress it.
    assign overflow = (op == op_step) && wrap;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= min_q;
        else      count <= count_d;
    end

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: four parameterisations driven with directed
// and random en/clr, compared against a plain-arithmetic reference model.
module tb_counter;

    localparam int n_dut = 4;
    // a: basic decade, b: step with overshoot, c: max = 2**nbits-1, d: step > range
    localparam int p_min  [n_dut] = '{0, 2, 250, 3};
    localparam int p_max  [n_dut] = '{9, 10, 255, 6};
    localparam int p_step [n_dut] = '{1, 3, 1, 5};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic [3:0] clr;
    logic [3:0] cnt_a, cnt_b, cnt_d;
    logic [7:0] cnt_c;
    logic [3:0] ovf;
`ifdef COUNTER_LOAD_EN
    logic [3:0] load;
    logic [3:0] lv_a, lv_b, lv_d;
    logic [7:0] lv_c;
`endif

    int model [n_dut];
    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    counter #(.nbits(4), .min(0), .max(9), .step(1)) u_a (
        .clk(clk), .rst(rst), .clr(clr[0]), .en(en[0]),
`ifdef COUNTER_LOAD_EN
        .load(load[0]), .load_value(lv_a),
`endif
        .count(cnt_a), .overflow(ovf[0]));

    counter #(.nbits(4), .min(2), .max(10), .step(3)) u_b (
        .clk(clk), .rst(rst), .clr(clr[1]), .en(en[1]),
`ifdef COUNTER_LOAD_EN
        .load(load[1]), .load_value(lv_b),
`endif
        .count(cnt_b), .overflow(ovf[1]));

    counter #(.nbits(8), .min(250)) u_c (
        .clk(clk), .rst(rst), .clr(clr[2]), .en(en[2]),
`ifdef COUNTER_LOAD_EN
        .load(load[2]), .load_value(lv_c),
`endif
        .count(cnt_c), .overflow(ovf[2]));

    counter #(.nbits(4), .min(3), .max(6), .step(5)) u_d (
        .clk(clk), .rst(rst), .clr(clr[3]), .en(en[3]),
`ifdef COUNTER_LOAD_EN
        .load(load[3]), .load_value(lv_d),
`endif
        .count(cnt_d), .overflow(ovf[3]));

    function automatic logic [31:0] observed(input int i);
        case (i)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            2:       return 32'(cnt_c);
            default: return 32'(cnt_d);
        endcase
    endfunction

    function automatic bit load_of(input int i);
`ifdef COUNTER_LOAD_EN
        return load[i];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lv_of(input int i);
`ifdef COUNTER_LOAD_EN
        case (i)
            0:       return int'(lv_a);
            1:       return int'(lv_b);
            2:       return int'(lv_c);
            default: return int'(lv_d);
        endcase
`else
        return i - i;
`endif
    endfunction

    // Overflow means "the next enabled step would pass max".
    function automatic bit model_ovf(input int i);
        return en[i] && !clr[i] && !load_of(i) && (model[i] + p_step[i] > p_max[i]);
    endfunction

    function automatic int model_next(input int i);
        int v;
        if (clr[i]) return p_min[i];
        if (load_of(i)) begin
            v = lv_of(i);
            if (v < p_min[i]) return p_min[i];
            if (v > p_max[i]) return p_max[i];
            return v;
        end
        if (!en[i]) return model[i];
        return (model[i] + p_step[i] > p_max[i]) ? p_min[i] : model[i] + p_step[i];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < n_dut; i++)
            check($sformatf("%s_count%0d", tag, i), observed(i), 32'(model[i]));
    endtask

    task automatic check_ovfs(input string tag);
        for (int i = 0; i < n_dut; i++)
            check($sformatf("%s_ovf%0d", tag, i), 32'(ovf[i]), 32'(model_ovf(i)));
    endtask

    // Inputs are already applied; check overflow, clock once, check count.
    task automatic cycle(input string tag);
        int nxt [n_dut];
        #1;
        check_ovfs(tag);
        for (int i = 0; i < n_dut; i++) nxt[i] = rst ? model_next(i) : p_min[i];
        @(posedge clk);
        model = nxt;
        #1;
        check_counts(tag);
    endtask

    initial begin
        rst = 1'b0;
        en  = 4'h0;
        clr = 4'h0;
`ifdef COUNTER_LOAD_EN
        load = 4'h0;
        lv_a = '0; lv_b = '0; lv_c = '0; lv_d = '0;
`endif
        for (int i = 0; i < n_dut; i++) model[i] = p_min[i];

        #12;
        check_counts("reset");
        check_ovfs("reset");
        rst = 1'b1;

        // All counters enabled for 12 cycles: a counts 0..9,0,1,2; b 2,5,8,2,...
        en = 4'hF;
        repeat (12) cycle("run12");

        // Bring a to 5, then clear everything with en still high.
        en = 4'b0001;
        repeat (3) cycle("to5");
        check("a_at5", observed(0), 32'd5);
        en  = 4'hF;
        clr = 4'hF;
        cycle("clr");
        check("a_after_clr", observed(0), 32'd0);
        clr = 4'h0;

        // a parked at max with en low: overflow stays low, count holds.
        en = 4'b0001;
        repeat (9) cycle("to9");
        en = 4'h0;
        repeat (3) cycle("hold9");
        check("a_hold9", observed(0), 32'd9);
        en = 4'b0001;
        #1;
        check("a_ovf_at9", 32'(ovf[0]), 32'd1);
        cycle("wrap9");
        check("a_wrapped", observed(0), 32'd0);

        // Random enables with occasional clears (and loads when present).
        repeat (300) begin
            en = 4'($urandom);
            for (int i = 0; i < n_dut; i++) clr[i] = ($urandom_range(15) == 0);
`ifdef COUNTER_LOAD_EN
            for (int i = 0; i < n_dut; i++) load[i] = ($urandom_range(7) == 0);
            lv_a = 4'($urandom); lv_b = 4'($urandom);
            lv_c = 8'($urandom); lv_d = 4'($urandom);
`endif
            cycle("rand");
        end
        clr = 4'h0;
`ifdef COUNTER_LOAD_EN
        load = 4'h0;
`endif

        // Asynchronous reset mid-cycle with a at 7.
        clr = 4'b0001;
        en  = 4'b0001;
        cycle("pre7");
        clr = 4'h0;
        repeat (7) cycle("to7");
        check("a_at7", observed(0), 32'd7);
        rst = 1'b0;
        #2;
        for (int i = 0; i < n_dut; i++) model[i] = p_min[i];
        check_counts("async_rst");
        en = 4'hF;
        repeat (3) cycle("in_rst");
        rst = 1'b1;
        repeat (3) cycle("post_rst");
        check("a_post_rst", observed(0), 32'd3);

`ifdef COUNTER_LOAD_EN
        en   = 4'h0;
        load = 4'b0010;
        lv_b = 4'd12;
        cycle("load12");
        check("b_load12", observed(1), 32'd10);
        lv_b = 4'd0;
        cycle("load0");
        check("b_load0", observed(1), 32'd2);
        lv_b = 4'd7;
        clr  = 4'b0010;
        cycle("load_clr");
        check("b_load_clr", observed(1), 32'd2);
        clr  = 4'h0;
        load = 4'h0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
